// File: rtl/mem_stage_if.sv
// EX -> MEM stage bundle: execute-stage results and control going in,
// MEM/WB pipeline state, forwarding sources and branch redirect coming out.
interface mem_stage_if;
  logic        stall_MEM;
  logic        flush_EX;
  logic [31:0] ALU_OUT_EX;
  logic        ZERO_EX;
  logic [31:0] PC_Branch_EX;
  logic [31:0] STORE_DATA_EX;
  logic [2:0]  FUNCT3_EX;
  logic [4:0]  RD_EX;
  logic        RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX;

  logic [31:0] ALU_OUT_MEM;
  logic [4:0]  RD_MEM;
  logic        RegWrite_MEM;
  logic [31:0] PC_Branch_MEM;
  logic        PCSrc_MEM;
  logic [31:0] ALU_DATA_WB;
  logic [4:0]  RD_WB;
  logic        RegWrite_WB;
  logic        misalign_WB;

  modport master (
    output stall_MEM, flush_EX, ALU_OUT_EX, ZERO_EX, PC_Branch_EX, STORE_DATA_EX,
           FUNCT3_EX, RD_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX,
    input  ALU_OUT_MEM, RD_MEM, RegWrite_MEM, PC_Branch_MEM, PCSrc_MEM,
           ALU_DATA_WB, RD_WB, RegWrite_WB, misalign_WB
  );

  modport slave (
    input  stall_MEM, flush_EX, ALU_OUT_EX, ZERO_EX, PC_Branch_EX, STORE_DATA_EX,
           FUNCT3_EX, RD_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX,
    output ALU_OUT_MEM, RD_MEM, RegWrite_MEM, PC_Branch_MEM, PCSrc_MEM,
           ALU_DATA_WB, RD_WB, RegWrite_WB, misalign_WB
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, byte-lane data RAM with registered read,
// MEM/WB register and load formatting.
module mem_stage #(
  parameter int DMEM_ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);
  localparam int DEPTH = 1 << DMEM_ADDR_W;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] pcb;
    logic [31:0] sdata;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw, m2r, mr, mw, br;
  } exmem_t;

  exmem_t ex_d, ex_q;

  // EX/MEM next state: stall holds, flush injects an all-zero bubble
  always_comb begin
    ex_d = ex_q;
    if (!bus.stall_MEM) begin
      if (bus.flush_EX) begin
        ex_d = '0;
      end else begin
        ex_d.alu   = bus.ALU_OUT_EX;
        ex_d.zero  = bus.ZERO_EX;
        ex_d.pcb   = bus.PC_Branch_EX;
        ex_d.sdata = bus.STORE_DATA_EX;
        ex_d.f3    = bus.FUNCT3_EX;
        ex_d.rd    = bus.RD_EX;
        ex_d.rw    = bus.RegWrite_EX;
        ex_d.m2r   = bus.MemtoReg_EX;
        ex_d.mr    = bus.MemRead_EX;
        ex_d.mw    = bus.MemWrite_EX;
        ex_d.br    = bus.Branch_EX;
      end
    end
  end

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  // Address decode; upper address bits are dropped so accesses wrap
  logic [DMEM_ADDR_W-1:0] widx;
  logic [1:0]             off;
  logic                   misal;
  logic                   wr_en;
  logic                   unused_addr;

  assign widx        = ex_q.alu[DMEM_ADDR_W+1:2];
  assign off         = ex_q.alu[1:0];
  assign unused_addr = ^ex_q.alu[31:DMEM_ADDR_W+2];
  assign misal       = (ex_q.f3[1:0] == 2'b01 && off[0]) ||
                       (ex_q.f3[1:0] == 2'b10 && off != 2'b00) ||
                       (ex_q.f3[1:0] == 2'b11);
  assign wr_en       = ex_q.mw & ~misal & ~bus.stall_MEM & ~reset;

  // Byte-lane enables and lane-replicated store data
  logic [3:0]  be;
  logic [31:0] wdata;
  always_comb begin
    be    = 4'b0000;
    wdata = ex_q.sdata;
    case (ex_q.f3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{ex_q.sdata[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{ex_q.sdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // One RAM bank per byte lane; the read register freezes with the stall so a
  // held load result stays valid in WB
  logic [31:0] rdata;
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] bank [DEPTH];
    logic [7:0] rd_q;
    // Lane write and registered read (old data on a same-address write)
    always_ff @(posedge clk) begin
      if (wr_en && be[l]) bank[widx] <= wdata[8*l +: 8];
      if (!bus.stall_MEM) rd_q <= bank[widx];
    end
    assign rdata[8*l +: 8] = rd_q;
  end

  // MEM/WB state, including what the load formatter needs after the RAM read
  logic [31:0] wb_alu_q;
  logic [4:0]  wb_rd_q;
  logic        wb_rw_q, wb_mis_q, wb_ld_q, wb_bad_q;
  logic [2:0]  wb_f3_q;
  logic [1:0]  wb_off_q;

  // MEM/WB register: a stall bubbles the control bits but keeps the data
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_alu_q <= '0;
      wb_rd_q  <= '0;
      wb_rw_q  <= 1'b0;
      wb_mis_q <= 1'b0;
      wb_ld_q  <= 1'b0;
      wb_bad_q <= 1'b0;
      wb_f3_q  <= '0;
      wb_off_q <= '0;
    end else if (bus.stall_MEM) begin
      wb_rw_q  <= 1'b0;
      wb_mis_q <= 1'b0;
    end else begin
      wb_alu_q <= ex_q.alu;
      wb_rd_q  <= ex_q.rd;
      wb_rw_q  <= ex_q.rw;
      wb_mis_q <= (ex_q.mr | ex_q.mw) & misal;
      wb_ld_q  <= ex_q.m2r;
      wb_bad_q <= misal;
      wb_f3_q  <= ex_q.f3;
      wb_off_q <= off;
    end
  end

  // Load lane select and sign/zero extension; misaligned loads yield 0
  logic [31:0] ld_data;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  always_comb begin
    ld_b    = rdata[{wb_off_q, 3'b000} +: 8];
    ld_h    = wb_off_q[1] ? rdata[31:16] : rdata[15:0];
    ld_data = '0;
    if (!wb_bad_q) begin
      case (wb_f3_q[1:0])
        2'b00:   ld_data = {{24{ld_b[7] & ~wb_f3_q[2]}}, ld_b};
        2'b01:   ld_data = {{16{ld_h[15] & ~wb_f3_q[2]}}, ld_h};
        2'b10:   ld_data = rdata;
        default: ld_data = '0;
      endcase
    end
  end

  assign bus.ALU_OUT_MEM   = ex_q.alu;
  assign bus.RD_MEM        = ex_q.rd;
  assign bus.RegWrite_MEM  = ex_q.rw;
  assign bus.PC_Branch_MEM = ex_q.pcb;
  assign bus.PCSrc_MEM     = ex_q.br & ex_q.zero;
  assign bus.ALU_DATA_WB   = wb_ld_q ? ld_data : wb_alu_q;
  assign bus.RD_WB         = wb_rd_q;
  assign bus.RegWrite_WB   = wb_rw_q;
  assign bus.misalign_WB   = wb_mis_q;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage RISC-V core, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register, a word-organised synchronous data RAM with byte-lane stores and sign/zero-extending loads, and the MEM/WB pipeline register.
- Outputs ALU_OUT_MEM and ALU_DATA_WB, which are the execute stage's forwarding sources, plus the branch redirect.

Parameters:
- DMEM_ADDR_W, 10, word-address width; RAM depth = 2**DMEM_ADDR_W words of 32 bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- stall_MEM  in  1  freezes the EX/MEM register.
- flush_EX  in  1  EX/MEM captures a bubble instead of the EX instruction.
- ALU_OUT_EX  in  32  ALU result, used as load/store byte address.
- ZERO_EX  in  1  ALU zero flag.
- PC_Branch_EX  in  32  branch target.
- STORE_DATA_EX  in  32  forwarded rs2 value (pre-immediate mux).
- FUNCT3_EX  in  3  load/store size and sign.
- RD_EX  in  5  destination register.
- RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX  in  1 each  control bits.
- ALU_OUT_MEM  out  32  registered ALU result (forward source).
- RD_MEM  out  5  registered rd.
- RegWrite_MEM  out  1  registered control bit.
- PC_Branch_MEM  out  32  registered target.
- PCSrc_MEM  out  1  Branch_MEM & ZERO_MEM, combinational from the register.
- ALU_DATA_WB  out  32  writeback value (forward source).
- RD_WB  out  5  registered rd.
- RegWrite_WB  out  1  registered control bit.
- misalign_WB  out  1  misaligned-access flag of the instruction in WB.

Behaviour:
- Reset: every EX/MEM and MEM/WB field clears to 0, so all outputs are 0 from the cycle after reset is sampled. RAM contents are not reset. A store in MEM while reset=1 is suppressed.
- EX/MEM update, in priority order:
  - reset: clear.
  - stall_MEM: hold.
  - flush_EX: load a bubble (all control bits 0; data fields don't-care, driven 0).
  - otherwise: capture the EX inputs.
- Address decode: word index = ALU_OUT_MEM[DMEM_ADDR_W+1:2]; byte offset = ALU_OUT_MEM[1:0]. Upper bits are ignored, so addresses wrap modulo RAM size.
- Misaligned condition:
  - halfword (funct3[1:0]=01) with offset[0]=1, or
  - word (funct3[1:0]=10) with offset≠0, or
  - funct3[1:0]=11.
  - Flag is registered into misalign_WB only for loads and stores.
- Store: RAM write on the rising edge when MemWrite_MEM & ~misaligned & ~stall_MEM & ~reset.
  - SB: byte lane = offset, data = STORE_DATA[7:0].
  - SH: lanes offset..offset+1, data = STORE_DATA[15:0].
  - SW: all 4 lanes.
  - Other lanes are unchanged.
- Load: the RAM read is synchronous and lands in the MEM/WB register at the same edge that advances the instruction.
  - Lane selection by offset.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
  - A misaligned load returns 0.
- Read-during-write: a load never coexists with a store in MEM. Read-old-data is acceptable.
- MEM/WB update:
  - reset: clear.
  - stall_MEM: bubble (RegWrite_WB=0, misalign_WB=0, ALU_DATA_WB holds).
  - otherwise: RD_WB ← RD_MEM; RegWrite_WB ← RegWrite_MEM; ALU_DATA_WB ← (MemtoReg_MEM ? load_data : ALU_OUT_MEM).
- Latency: EX inputs appear on the *_MEM outputs 1 cycle later and on the *_WB outputs 2 cycles later. A load value is forwardable from ALU_DATA_WB only.
- stall_MEM and flush_EX asserted together: stall wins. The flush is lost, and the hazard unit must reassert it.

Test Plan:
- Reset mid-stream:
  - Stimulus: RegWrite_EX=1, RD_EX=5 for 2 cycles, then reset for 1 cycle.
  - Required: all *_MEM and *_WB outputs are 0 the next cycle; PCSrc_MEM=0.
- Byte/half stores then loads:
  - Stimulus: SW 0x11223344 @0x10, SB 0xAA @0x11, SH 0xBEEF @0x12; then LW @0x10, LB @0x11, LBU @0x11, LH @0x12.
  - Required ALU_DATA_WB: 0xBEEFAA44, 0xFFFFFFAA, 0x000000AA, 0xFFFFBEEF.
- Misaligned access:
  - Stimulus: SW 0xDEADBEEF @0x21, then LW @0x20 (previously 0).
  - Required: misalign_WB=1 for the store, RAM unchanged, LW returns 0.
  - Also: LH @0x23 → ALU_DATA_WB=0, misalign_WB=1.
- Branch redirect:
  - Stimulus: Branch_EX=1, ZERO_EX=1, PC_Branch_EX=0x40.
  - Required: the next cycle PCSrc_MEM=1 and PC_Branch_MEM=0x40. With ZERO_EX=0, PCSrc_MEM=0.
- Stall:
  - Stimulus: SW 0x5 @0x30 with stall_MEM=1 for 3 cycles, then released.
  - Required: the MEM fields hold; RegWrite_WB=0 throughout; exactly one write occurs, on the release edge; a subsequent LW @0x30 returns 5.
- Flush, and stall+flush:
  - Stimulus: flush_EX=1 with MemWrite_EX=1 @0x34.
  - Required: no write; RegWrite_MEM=0.
  - Stimulus: stall_MEM=flush_EX=1 together.
  - Required: EX/MEM holds its previous instruction.
- Wrap-around:
  - Stimulus: with DMEM_ADDR_W=10, SW 0x7 @0x1000, then LW @0x0.
  - Required: ALU_DATA_WB=0x7.
